// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  cdb_arbiter_if
//  Producer-to-CDB bus: per-producer results in, one broadcast out.
//  Revision: 1.0
// ============================================================================
interface cdb_arbiter_if #(
  parameter int NUM_SRC   = 2,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
);
  localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]           src_en;
  logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_idx;
  logic [NUM_SRC*DATA_W-1:0]    src_val;
  logic [NUM_SRC-1:0]           src_full;
  logic                         cdb_en;
  logic [ROB_IDX_W-1:0]         cdb_rob_idx;
  logic [DATA_W-1:0]            cdb_val;
  logic [c_SRC_W-1:0]           cdb_src;
  logic                         err_overflow;

  // The arbiter owns the broadcast, so it takes the master side.
  modport master (
    input  src_en, src_rob_idx, src_val,
    output src_full, cdb_en, cdb_rob_idx, cdb_val, cdb_src, err_overflow
  );

  modport slave (
    output src_en, src_rob_idx, src_val,
    input  src_full, cdb_en, cdb_rob_idx, cdb_val, cdb_src, err_overflow
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  cdb_arbiter
//  Per-producer result queues merged round-robin onto one registered CDB.
//  Revision: 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int QDEPTH    = 2,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32,
  parameter int BYPASS    = 0
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           roll_back,
  cdb_arbiter_if.master  bus
);
  localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int c_CNT_W = $clog2(QDEPTH + 1);

  typedef logic [c_CNT_W-1:0] cnt_t;

  logic [NUM_SRC-1:0]           w_full;
  logic [NUM_SRC-1:0]           w_nonempty;
  logic [NUM_SRC-1:0]           w_bcand;
  logic [NUM_SRC-1:0]           w_cand;
  logic [NUM_SRC-1:0]           w_sel;
  logic [NUM_SRC-1:0]           w_pop;
  logic [NUM_SRC-1:0]           w_bypass;
  logic [NUM_SRC-1:0]           w_push;
  logic [NUM_SRC*ROB_IDX_W-1:0] w_head_idx;
  logic [NUM_SRC*DATA_W-1:0]    w_head_val;
  logic                         w_found;
  logic [c_SRC_W-1:0]           w_win;
  logic [ROB_IDX_W-1:0]         w_win_idx;
  logic [DATA_W-1:0]            w_win_val;

  logic [c_SRC_W-1:0]   r_rr;
  logic                 r_cdb_en;
  logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
  logic [DATA_W-1:0]    r_cdb_val;
  logic [c_SRC_W-1:0]   r_cdb_src;
  logic                 r_err;

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_queue
      logic [ROB_IDX_W-1:0] r_mem_idx [QDEPTH];
      logic [DATA_W-1:0]    r_mem_val [QDEPTH];
      logic [c_PTR_W-1:0]   r_head;
      logic [c_PTR_W-1:0]   r_tail;
      cnt_t                 r_cnt;

      // Full is taken from the registered count alone, never from a same-cycle pop.
      assign w_full[gi]     = (r_cnt == cnt_t'(QDEPTH));
      assign w_nonempty[gi] = (r_cnt != '0);
      assign w_head_idx[gi*ROB_IDX_W +: ROB_IDX_W] = r_mem_idx[r_head];
      assign w_head_val[gi*DATA_W +: DATA_W]       = r_mem_val[r_head];

      always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
          r_head <= '0;
          r_tail <= '0;
          r_cnt  <= '0;
        end else if (rdy_in) begin
          if (roll_back) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
          end else begin
            if (w_push[gi]) r_tail <= f_inc(r_tail);
            if (w_pop[gi])  r_head <= f_inc(r_head);
            r_cnt <= r_cnt + cnt_t'(w_push[gi]) - cnt_t'(w_pop[gi]);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rdy_in && !roll_back && w_push[gi]) begin
          r_mem_idx[r_tail] <= bus.src_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W];
          r_mem_val[r_tail] <= bus.src_val[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  assign w_bcand = (BYPASS != 0) ? (~w_nonempty & bus.src_en) : '0;
  assign w_cand  = w_nonempty | w_bcand;

  // Scan from r_rr upward; the outer loop sets priority order.
  always_comb begin
    w_found   = 1'b0;
    w_sel     = '0;
    w_win     = '0;
    w_win_idx = '0;
    w_win_val = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_found && w_cand[i] && (((int'(r_rr) + k) % NUM_SRC) == i)) begin
          w_found  = 1'b1;
          w_sel[i] = 1'b1;
          w_win    = c_SRC_W'(i);
          if (w_bcand[i]) begin
            w_win_idx = bus.src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            w_win_val = bus.src_val[i*DATA_W +: DATA_W];
          end else begin
            w_win_idx = w_head_idx[i*ROB_IDX_W +: ROB_IDX_W];
            w_win_val = w_head_val[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign w_pop    = w_sel & ~w_bcand;
  assign w_bypass = w_sel & w_bcand;
  assign w_push   = bus.src_en & ~w_full & ~w_bypass;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_rr          <= '0;
      r_cdb_en      <= 1'b0;
      r_cdb_rob_idx <= '0;
      r_cdb_val     <= '0;
      r_cdb_src     <= '0;
      r_err         <= 1'b0;
    end else if (rdy_in) begin
      if (roll_back) begin
        r_cdb_en <= 1'b0;
        r_rr     <= '0;
      end else begin
        if (|(bus.src_en & w_full)) r_err <= 1'b1;
        r_cdb_en <= w_found;
        if (w_found) begin
          r_cdb_rob_idx <= w_win_idx;
          r_cdb_val     <= w_win_val;
          r_cdb_src     <= w_win;
          r_rr          <= (w_win == c_SRC_W'(NUM_SRC - 1)) ? '0 : w_win + 1'b1;
        end
      end
    end
  end

  assign bus.src_full     = w_full;
  assign bus.cdb_en       = r_cdb_en;
  assign bus.cdb_rob_idx  = r_cdb_rob_idx;
  assign bus.cdb_val      = r_cdb_val;
  assign bus.cdb_src      = r_cdb_src;
  assign bus.err_overflow = r_err;
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_cdb_arbiter
//  Two arbiters (3-source no-bypass, 2-source bypass) against a queue model.
//  Revision: 1.0
// ============================================================================
module tb_cdb_arbiter;
  localparam int QD = 2;
  typedef logic [35:0] ent_t;

  logic clk = 1'b0;
  logic rst_n, rdy, rb;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(3), .ROB_IDX_W(4), .DATA_W(32)) if_a ();
  cdb_arbiter_if #(.NUM_SRC(2), .ROB_IDX_W(4), .DATA_W(32)) if_b ();

  cdb_arbiter #(.NUM_SRC(3), .QDEPTH(QD), .ROB_IDX_W(4), .DATA_W(32), .BYPASS(0)) dut_a (
    .clk(clk), .rst_in(rst_n), .rdy_in(rdy), .roll_back(rb), .bus(if_a));
  cdb_arbiter #(.NUM_SRC(2), .QDEPTH(QD), .ROB_IDX_W(4), .DATA_W(32), .BYPASS(1)) dut_b (
    .clk(clk), .rst_in(rst_n), .rdy_in(rdy), .roll_back(rb), .bus(if_b));

  int checks = 0;
  int failures = 0;

  // Reference model: queues 0..2 belong to dut_a, 3..4 to dut_b.
  ent_t        mq [5][$];
  int          rr [2];
  logic        me_en [2];
  logic [3:0]  me_idx [2];
  logic [31:0] me_val [2];
  int          me_src [2];
  logic        me_err [2];
  int          seen0 [$];
  int          seq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) mq[i].delete();
    for (int d = 0; d < 2; d++) begin
      rr[d] = 0; me_en[d] = 1'b0; me_idx[d] = '0; me_val[d] = '0; me_src[d] = 0; me_err[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input int n, input int base, input bit byp,
                            input logic [2:0] en, input logic [11:0] ix, input logic [95:0] vl);
    bit   full [3];
    bit   cand [3];
    int   w, bw, j;
    ent_t e;
    w = -1; bw = -1;
    if (rb) begin
      for (int i = 0; i < n; i++) mq[base+i].delete();
      me_en[d] = 1'b0;
      rr[d] = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      full[i] = (mq[base+i].size() == QD);
      cand[i] = (mq[base+i].size() > 0) || (byp && en[i]);
    end
    for (int k = 0; k < n; k++) begin
      j = (rr[d] + k) % n;
      if (w < 0 && cand[j]) w = j;
    end
    for (int i = 0; i < n; i++) if (en[i] && full[i]) me_err[d] = 1'b1;
    if (w >= 0) begin
      me_en[d] = 1'b1;
      me_src[d] = w;
      rr[d] = (w + 1) % n;
      if (mq[base+w].size() == 0) begin
        bw = w;
        me_idx[d] = ix[w*4 +: 4];
        me_val[d] = vl[w*32 +: 32];
      end else begin
        e = mq[base+w].pop_front();
        me_idx[d] = e[35:32];
        me_val[d] = e[31:0];
      end
    end else begin
      me_en[d] = 1'b0;
    end
    for (int i = 0; i < n; i++)
      if (en[i] && !full[i] && i != bw) mq[base+i].push_back({ix[i*4 +: 4], vl[i*32 +: 32]});
  endtask

  function automatic logic [2:0] exp_full(input int n, input int base);
    logic [2:0] f;
    f = '0;
    for (int i = 0; i < n; i++) f[i] = (mq[base+i].size() == QD);
    return f;
  endfunction

  task automatic compare_all();
    chk("a_cdb_en",  64'(if_a.cdb_en),       64'(me_en[0]));
    chk("a_cdb_idx", 64'(if_a.cdb_rob_idx),  64'(me_idx[0]));
    chk("a_cdb_val", 64'(if_a.cdb_val),      64'(me_val[0]));
    chk("a_cdb_src", 64'(if_a.cdb_src),      64'(me_src[0]));
    chk("a_full",    64'(if_a.src_full),     64'(exp_full(3, 0)));
    chk("a_err",     64'(if_a.err_overflow), 64'(me_err[0]));
    chk("b_cdb_en",  64'(if_b.cdb_en),       64'(me_en[1]));
    chk("b_cdb_idx", 64'(if_b.cdb_rob_idx),  64'(me_idx[1]));
    chk("b_cdb_val", 64'(if_b.cdb_val),      64'(me_val[1]));
    chk("b_cdb_src", 64'(if_b.cdb_src),      64'(me_src[1]));
    chk("b_full",    64'(if_b.src_full),     64'(exp_full(2, 3)));
    chk("b_err",     64'(if_b.err_overflow), 64'(me_err[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && rdy) begin
      model_step(0, 3, 0, 1'b0, if_a.src_en, if_a.src_rob_idx, if_a.src_val);
      model_step(1, 2, 3, 1'b1, {1'b0, if_b.src_en}, {4'h0, if_b.src_rob_idx}, {32'h0, if_b.src_val});
    end
    #1;
    compare_all();
  endtask

  task automatic idle_all();
    if_a.src_en = '0; if_a.src_rob_idx = '0; if_a.src_val = '0;
    if_b.src_en = '0; if_b.src_rob_idx = '0; if_b.src_val = '0;
  endtask

  task automatic drive_rand();
    if_a.src_en      = 3'($urandom);
    if_a.src_rob_idx = 12'($urandom);
    if_a.src_val     = {$urandom, $urandom, $urandom};
    if_b.src_en      = 2'($urandom);
    if_b.src_rob_idx = 8'($urandom);
    if_b.src_val     = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rb = 1'b0;
    idle_all();
    model_reset();
    #1 compare_all();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("rst_cdb_en", 64'(if_a.cdb_en), 64'd0);
    chk("rst_full",   64'(if_a.src_full), 64'd0);

    // Single push from source 1
    if_a.src_en = 3'b010; if_a.src_rob_idx = 12'h050; if_a.src_val = {32'h0, 32'hDEADBEEF, 32'h0};
    tick();
    chk("single_t0_en", 64'(if_a.cdb_en), 64'd0);
    idle_all();
    tick();
    chk("single_en",  64'(if_a.cdb_en), 64'd1);
    chk("single_idx", 64'(if_a.cdb_rob_idx), 64'd5);
    chk("single_val", 64'(if_a.cdb_val), 64'hDEADBEEF);
    chk("single_src", 64'(if_a.cdb_src), 64'd1);
    tick();
    chk("single_t2_en", 64'(if_a.cdb_en), 64'd0);

    // Backpressure and overflow on source 0
    seen0.delete();
    for (int k = 0; k < 3; k++) begin
      if_a.src_en = 3'b111;
      if_a.src_rob_idx = {4'(10 + k), 4'hC, 4'(k + 1)};
      if_a.src_val = {32'(k + 200), 32'(k + 100), 32'(k + 1)};
      tick();
      if (if_a.cdb_en && if_a.cdb_src == 2'd0) seen0.push_back(int'(if_a.cdb_rob_idx));
      if (k == 1) chk("ovf_full0", 64'(if_a.src_full[0]), 64'd1);
    end
    chk("ovf_err", 64'(if_a.err_overflow), 64'd1);
    idle_all();
    repeat (8) begin
      tick();
      if (if_a.cdb_en && if_a.cdb_src == 2'd0) seen0.push_back(int'(if_a.cdb_rob_idx));
    end
    chk("ovf_count",  64'(seen0.size()), 64'd2);
    chk("ovf_first",  64'(seen0[0]), 64'd1);
    chk("ovf_second", 64'(seen0[1]), 64'd2);

    // Asynchronous reset with queues non-empty
    drive_rand();
    if_a.src_en = 3'b111; if_b.src_en = 2'b11;
    tick();
    idle_all();
    #1 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    chk("arst_en",  64'(if_a.cdb_en), 64'd0);
    chk("arst_err", 64'(if_a.err_overflow), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_full_after", 64'(if_a.src_full), 64'd0);

    // Flush with queues loaded and same-cycle pushes
    repeat (3) begin
      drive_rand();
      if_a.src_en = 3'b111; if_b.src_en = 2'b00;
      tick();
    end
    rb = 1'b1;
    drive_rand();
    if_a.src_en = 3'b111; if_b.src_en = 2'b11;
    tick();
    rb = 1'b0;
    idle_all();
    chk("rb_en",   64'(if_a.cdb_en), 64'd0);
    chk("rb_full", 64'(if_a.src_full), 64'd0);
    repeat (4) begin
      tick();
      chk("rb_quiet", 64'(if_a.cdb_en | if_b.cdb_en), 64'd0);
    end

    // Round-robin under sustained requests
    seq.delete();
    for (int k = 0; k < 8; k++) begin
      drive_rand();
      if_a.src_en = 3'b111; if_b.src_en = 2'b00;
      tick();
      if (if_a.cdb_en) seq.push_back(int'(if_a.cdb_src));
    end
    idle_all();
    repeat (8) tick();
    for (int k = 0; k < 6; k++) chk("rr_seq", 64'(seq[k]), 64'(k % 3));

    // Bypass, then rdy_in low freezes everything
    if_b.src_en = 2'b01; if_b.src_rob_idx = 8'h07; if_b.src_val = {32'h0, 32'h12345678};
    tick();
    chk("byp_en",  64'(if_b.cdb_en), 64'd1);
    chk("byp_idx", 64'(if_b.cdb_rob_idx), 64'd7);
    chk("byp_val", 64'(if_b.cdb_val), 64'h12345678);
    chk("byp_src", 64'(if_b.cdb_src), 64'd0);
    rdy = 1'b0;
    if_b.src_en = 2'b11; if_a.src_en = 3'b111;
    repeat (3) begin
      tick();
      chk("frz_en",  64'(if_b.cdb_en), 64'd1);
      chk("frz_idx", 64'(if_b.cdb_rob_idx), 64'd7);
    end
    rdy = 1'b1;
    idle_all();
    tick();
    chk("frz_after_b", 64'(if_b.cdb_en), 64'd0);
    chk("frz_after_a", 64'(if_a.cdb_en), 64'd0);

    // Randomized traffic with occasional flushes and stalls
    repeat (300) begin
      drive_rand();
      rb  = ($urandom_range(0, 31) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      tick();
    end
    rb = 1'b0; rdy = 1'b1;
    idle_all();
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter. Merges write-back results from NUM_SRC execution producers (RS, LSB and future ALU/branch units) onto a single registered CDB broadcast per cycle.
- Each producer gets a private result queue. Arbitration is round-robin, and the queues are flushed on roll_back.
- Replaces the fixed two-producer point-to-point CDB wiring in the cpu top module. ROB, RS, LSB and decoder all consume its single broadcast.

Parameters:
- NUM_SRC, 2, number of producers (2..8).
- QDEPTH, 2, entries per producer queue (power of two, >=1).
- ROB_IDX_W, 4, ROB index width.
- DATA_W, 32, result value width.
- BYPASS, 0, 1 = a producer with an empty queue may win arbitration in the same cycle it presents.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; freezes the block when low.
- roll_back  in  1  misprediction flush from ROB.
- src_en  in  NUM_SRC  per-producer result valid.
- src_rob_idx  in  NUM_SRC*ROB_IDX_W  packed ROB indices; producer i at [i*ROB_IDX_W +: ROB_IDX_W].
- src_val  in  NUM_SRC*DATA_W  packed result values; producer i at [i*DATA_W +: DATA_W].
- src_full  out  NUM_SRC  per-producer backpressure; bit i = queue i holds QDEPTH entries.
- cdb_en  out  1  broadcast valid.
- cdb_rob_idx  out  ROB_IDX_W  broadcast ROB index.
- cdb_val  out  DATA_W  broadcast value.
- cdb_src  out  $clog2(NUM_SRC) (min 1)  index of the winning producer.
- err_overflow  out  1  sticky: a push was attempted while full.

Behaviour:
- Reset (rst_in=0, async): all queue counts/pointers 0, rr_ptr=0, cdb_en=0, cdb_rob_idx=0, cdb_val=0, cdb_src=0, err_overflow=0. src_full=0 after reset.
- All state changes occur on posedge clk only when rdy_in=1. With rdy_in=0, every register and output holds and inputs are ignored.
- src_full[i] is combinational from the registered count only (count_i==QDEPTH). It never depends on same-cycle pops.
- Push: src_en[i]=1 and src_full[i]=0 -> entry {rob_idx,val} written at tail i, unless it is bypassed.
- Dropped push: src_en[i]=1 and src_full[i]=1 -> entry dropped, err_overflow<=1. This holds even if queue i is popped in the same cycle.
- Candidates at each active edge:
  - queue i is a candidate if count_i>0;
  - if BYPASS=1, producer i is also a candidate if count_i==0 and src_en[i]=1, using the live inputs.
- Winner: first candidate scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
- On a winner w:
  - cdb_en<=1; cdb_rob_idx/cdb_val <= head of w (or live inputs if bypassed); cdb_src<=w;
  - pop head w, or skip enqueue if bypassed;
  - rr_ptr <= (w+1) mod NUM_SRC.
- No candidate: cdb_en<=0, cdb_rob_idx/cdb_val/cdb_src hold, rr_ptr holds.
- Latency, producer present at edge t, no contention:
  - BYPASS=0: enqueued at t, broadcast registered at t+1 (cdb_en high during cycle t+1..t+2), i.e. 2 edges from presentation to visibility;
  - BYPASS=1: cdb_en visible after edge t.
- Simultaneous push+pop on a non-full queue: count unchanged, FIFO order preserved.
- Pointer wrap-around is modulo QDEPTH.
- Each queue alone delivers in FIFO order. Across producers the order is only what round-robin gives.
- roll_back=1 at an active edge:
  - all counts/pointers <=0, cdb_en<=0, rr_ptr<=0;
  - same-cycle src_en inputs are discarded;
  - err_overflow is unaffected.
- roll_back with rdy_in=0 is ignored, as the ROB also holds.
- Fairness: under sustained requests from all producers, each wins exactly once per NUM_SRC consecutive broadcasts.
- cdb outputs are pure registers; there is no combinational path from src_* to cdb_*.

Test Plan:
- Reset: assert rst_in=0 mid-run with queues non-empty -> outputs 0 immediately without waiting for an edge; after release, src_full=0 and cdb_en=0 until the first push.
- Single push, NUM_SRC=2, QDEPTH=2, BYPASS=0: src 1 pushes {idx=5, val=0xDEADBEEF} at edge t -> cdb_en=1, cdb_rob_idx=5, cdb_val=0xDEADBEEF, cdb_src=1 after edge t+1; cdb_en=0 after t+2.
- Round-robin, NUM_SRC=3: all three push every cycle -> cdb_src sequence 0,1,2,0,1,2 starting from rr_ptr=0.
- Backpressure/overflow: src 0 pushes idx 1,2,3 on consecutive cycles while src 1 holds the bus -> src_full[0]=1 after two entries; idx 3 dropped; err_overflow=1; later broadcasts show idx 1 then 2 only.
- Flush: queues holding 2 entries each, roll_back=1 with src_en=3'b111 -> next cycle cdb_en=0, src_full=0, nothing from that cycle is ever broadcast.
- BYPASS=1 and rdy_in: empty queues, src 0 pushes idx=7 at edge t -> broadcast after edge t. Then rdy_in=0 for 3 cycles with src_en high -> outputs frozen and no entries captured.
